sram_fifo_controller: RTL
=========================

# sram_fifo_controller

Synchronous FIFO controller placed directly upstream of the team's dual-port SRAM macro (one write port, one read port, 1-cycle registered read). It turns a valid/ready producer stream into SRAM writes and SRAM reads back into a valid/ready consumer stream. A 2-entry output buffer absorbs the SRAM read latency, so the FIFO sustains one push and one pop per cycle.

## Interface
- `WIDTH`, 128: data word width; equals the SRAM `WIDTH`.
- `NUM_ROWS`, 4096: SRAM depth; must be a power of two, at least 2.
- `AddressWidth` (localparam): `$clog2(NUM_ROWS)`.
- `CountWidth` (localparam): `$clog2(NUM_ROWS+3)`.
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `in_valid` in 1: producer has a word.
- `in_ready` out 1: controller accepts the word this cycle.
- `in_data` in WIDTH: word to push.
- `out_valid` out 1: head word is available.
- `out_ready` in 1: consumer takes the head word.
- `out_data` out WIDTH: head word.
- `count` out CountWidth: total words held, counting SRAM, in-flight read and buffer.
- `sram_REB` out 1: SRAM read enable, active low.
- `sram_WEB` out 1: SRAM write enable, active low.
- `sram_AA` out AddressWidth: SRAM write address.
- `sram_AB` out AddressWidth: SRAM read address.
- `sram_D` out WIDTH: SRAM write data; equals `in_data`.
- `sram_M` out WIDTH: SRAM write mask; constant all-zeros (full overwrite).
- `sram_Q` in WIDTH: SRAM read data, valid the cycle after a read edge.

## Operation
- Push = `in_valid && in_ready` at a rising edge.
  - `sram_WEB = ~(in_valid && in_ready)`, `sram_AA = wr_ptr`.
  - `wr_ptr` increments modulo `NUM_ROWS`.
- `sram_occ` counts rows written but not yet issued for read, range 0..NUM_ROWS.
  - `in_ready = !RST && (sram_occ != NUM_ROWS)`.
  - There is no push-while-full bypass. A simultaneous read issue does not raise `in_ready` in the same cycle.
- Read issue happens when `sram_occ != 0` and `buf_cnt + inflight - pop < 2`.
  - `pop = out_valid && out_ready`.
  - When issuing: `sram_REB = 0`, `sram_AB = rd_ptr`; `rd_ptr` increments modulo `NUM_ROWS`; `inflight` is set for one cycle.
  - Otherwise `sram_REB = 1`.
- A row written at edge E is readable at the earliest at edge E+1. Read and write of the same address never coincide, because `sram_occ` counts only completed writes.
- Output buffer holds 2 entries in FIFO order.
  - When `inflight` is set, `sram_Q` is captured at the next edge.
  - `out_valid = buf_cnt != 0`; `out_data` = oldest entry.
  - Pop and capture in the same cycle leaves `buf_cnt` unchanged.
- `count = sram_occ + inflight + buf_cnt`; maximum value is `NUM_ROWS + 2`.
- Pointer wrap-around: `NUM_ROWS - 1` wraps to 0; no special case is needed.
- Asynchronous reset clears `wr_ptr`, `rd_ptr`, `sram_occ`, `inflight` and `buf_cnt`. SRAM contents are left as is.
  - Reset mid-operation discards all held words, including an in-flight read.

## Timing
- Reset values: `in_ready = 0` while `RST` is high, then 1. `out_valid = 0`, `count = 0`, `sram_REB = 1`, `sram_WEB = 1`, `out_data = 0`.
- Latency: a word pushed at edge E0 into an empty FIFO is read at E1, captured at E2, and `out_valid` is high after E2 (2 cycles).
- Throughput: one push and one pop per cycle in steady state, with no bubbles.
- `sram_WEB`, `sram_REB`, `sram_AB` and `in_ready` are combinational from state and inputs. `out_valid`, `out_data` and `count` come from registers.
- `out_data` stays stable while `out_valid && !out_ready`.

## Configuration
- `SRAM_FIFO_ALMOST_FULL_EN`, when defined:
  - adds parameter `ALMOST_FULL_THRESHOLD` (default `NUM_ROWS - 4`);
  - adds output `almost_full` (1 bit), registered, equal to `count >= ALMOST_FULL_THRESHOLD` after each edge, reset 0.
- Without the macro, neither the parameter nor the port exists, and the behaviour is otherwise identical.

## Structure
- Package `sram_fifo_pkg`:
  - holds the output-buffer depth constant `SramFifoBufDepth = 2`;
  - holds the SRAM read latency constant `SramReadLatency = 1`.
- Sub-module `sram_fifo_out_buffer`: 2-entry register FIFO with capture and pop inputs, `buf_cnt`, `out_valid` and `out_data`.
- The top level keeps the pointers, `sram_occ`, `inflight`, the read-issue logic and the SRAM port mapping.

## Test plan
- Reset then single push of 0xA5 at edge E0: `sram_WEB` is low in the push cycle with `AA = 0`; `sram_REB` is low in the next cycle with `AB = 0`; `out_valid` is high after E2 with `out_data = 0xA5`; `count` is 1 from E0.
- Fill: `NUM_ROWS = 8`, `out_ready = 0`, push 0..9.
  - After the 10th word `count = 10` and `in_ready = 0`.
  - An 11th `in_valid` is not accepted.
  - Draining returns 0..9 in order.
- Streaming: continuous push and pop of 100 incrementing words with `NUM_ROWS = 8`. Output equals input, no bubbles after the initial 2 cycles, and the pointers wrap without error.
- Backpressure: toggle `out_ready` pseudo-randomly during streaming. `out_data` stays stable when stalled, and no word is lost or duplicated.
- Mid-operation reset: pulse `RST` with 5 words held and a read in flight. Afterwards `count = 0` and `out_valid = 0`; the next push of 0x3C emerges as the first output.
- With `SRAM_FIFO_ALMOST_FULL_EN`, `NUM_ROWS = 8`, threshold 6: `almost_full` rises after the edge where `count` reaches 6 and falls after the edge where `count` drops to 5.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed FIFO controller.
// Optional feature macro: SRAM_FIFO_ALMOST_FULL_EN (see sram_fifo_controller).
package sram_fifo_pkg;

    // Entries in the register buffer that absorbs SRAM read latency
    localparam int SramFifoBufDepth = 2;

    // Cycles from SRAM read edge to data on sram_Q
    localparam int SramReadLatency = 1;

    // Width able to hold 0..SramFifoBufDepth
    localparam int SramFifoBufCntWidth = $clog2(SramFifoBufDepth + 1);

    typedef logic [SramFifoBufCntWidth-1:0] buf_cnt_t;

endpackage

// File: rtl/sram_fifo_out_buffer.sv
// Two-entry register FIFO holding words read back from the SRAM.
// head_q is always the oldest entry and drives out_data directly.
module sram_fifo_out_buffer
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output buf_cnt_t         buf_cnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    buf_cnt_t         cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    // Next-state: capture appends, pop shifts tail into head
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({capture, pop})
            2'b10: begin
                if (cnt_q == '0) head_d = cap_data;
                else             tail_d = cap_data;
                cnt_d = cnt_q + buf_cnt_t'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - buf_cnt_t'(1);
            end
            2'b11: begin
                // Pop and capture together: the new word lands behind whatever remains
                if (cnt_q == buf_cnt_t'(1)) begin
                    head_d = cap_data;
                end else begin
                    head_d = tail_q;
                    tail_d = cap_data;
                end
            end
            default: ;
        endcase
    end

    // Buffer registers, cleared by asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign buf_cnt   = cnt_q;
    assign out_valid = (cnt_q != '0);
    assign out_data  = head_q;

endmodule

// File: rtl/sram_fifo_controller.sv
// FIFO controller in front of a dual-port SRAM with 1-cycle registered read.
// Pushes become SRAM writes; reads are issued early enough that the
// 2-entry output buffer sustains one pop per cycle.
// Optional feature macro: SRAM_FIFO_ALMOST_FULL_EN adds parameter
// ALMOST_FULL_THRESHOLD and registered output almost_full.
module sram_fifo_controller
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH    = 128,
    parameter int NUM_ROWS = 4096,
`ifdef SRAM_FIFO_ALMOST_FULL_EN
    parameter int ALMOST_FULL_THRESHOLD = NUM_ROWS - 4,
`endif
    localparam int AddressWidth = $clog2(NUM_ROWS),
    localparam int CountWidth   = $clog2(NUM_ROWS + 3)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CountWidth-1:0]   count,
    output logic                    sram_REB,
    output logic                    sram_WEB,
    output logic [AddressWidth-1:0] sram_AA,
    output logic [AddressWidth-1:0] sram_AB,
    output logic [WIDTH-1:0]        sram_D,
    output logic [WIDTH-1:0]        sram_M,
    input  logic [WIDTH-1:0]        sram_Q
`ifdef SRAM_FIFO_ALMOST_FULL_EN
    ,
    output logic                    almost_full
`endif
);

    localparam int OccWidth  = AddressWidth + 1;
    localparam int PendWidth = SramFifoBufCntWidth + 1;

    logic [AddressWidth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AddressWidth-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OccWidth-1:0]        sram_occ_q, sram_occ_d;
    logic [SramReadLatency-1:0] inflight_q, inflight_d;
    logic [CountWidth-1:0]      count_q, count_d;

    buf_cnt_t             buf_cnt;
    logic                 push, pop, issue, capture;
    logic [PendWidth-1:0] pending;

    // Handshakes and read-issue decision
    always_comb begin
        in_ready = !RST && (sram_occ_q != OccWidth'(NUM_ROWS));
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        capture  = inflight_q[SramReadLatency-1];
        // Buffer slots committed after this edge: held + arriving - leaving
        pending  = PendWidth'(buf_cnt) + PendWidth'(capture) - PendWidth'(pop);
        issue    = (sram_occ_q != '0) && (pending < PendWidth'(SramFifoBufDepth));
    end

    // Pointer, occupancy and count next-state
    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + AddressWidth'(1) : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + AddressWidth'(1) : rd_ptr_q;
        sram_occ_d = sram_occ_q + OccWidth'(push) - OccWidth'(issue);
        inflight_d = SramReadLatency'(issue);
        // Net change of sram_occ + inflight + buf_cnt is always push - pop
        count_d    = count_q + CountWidth'(push) - CountWidth'(pop);
    end

    // Controller state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_occ_q <= '0;
            inflight_q <= '0;
            count_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_occ_q <= sram_occ_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    sram_fifo_out_buffer #(
        .WIDTH(WIDTH)
    ) u_out_buffer (
        .CLK      (CLK),
        .RST      (RST),
        .capture  (capture),
        .cap_data (sram_Q),
        .pop      (pop),
        .buf_cnt  (buf_cnt),
        .out_valid(out_valid),
        .out_data (out_data)
    );

`ifdef SRAM_FIFO_ALMOST_FULL_EN
    logic almost_full_q, almost_full_d;

    // Threshold flag tracks the post-edge count
    always_comb begin
        almost_full_d = (int'(count_d) >= ALMOST_FULL_THRESHOLD);
    end

    // Almost-full register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) almost_full_q <= 1'b0;
        else     almost_full_q <= almost_full_d;
    end

    assign almost_full = almost_full_q;
`endif

    assign count    = count_q;
    assign sram_WEB = ~push;
    assign sram_REB = ~issue;
    assign sram_AA  = wr_ptr_q;
    assign sram_AB  = rd_ptr_q;
    assign sram_D   = in_data;
    assign sram_M   = '0;

endmodule
